timer_fsm: RTL

TIMER_FSM -- requirements
Module: timer_fsm

---
 rtl/timer_fsm.sv | 133 +++++++++++++
 1 files changed

// File: rtl/timer_fsm.sv
// Fan-timer state machine: choose a 5/10/15 s preset, count whole seconds, pulse on completion.
// Optional macro TIMER_AUTO_CLEAR_EN: COMPLETE returns to INACTIVE by itself after one tick period.
module timer_fsm #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_btnTimer,
  input  logic        i_btnStart,
  input  logic        i_fanOn,
  output logic [2:0]  o_timerState,
  output logic [31:0] o_downCount,
  output logic        o_timeout
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    INACTIVE = 3'd0,
    T5       = 3'd1,
    T10      = 3'd2,
    T15      = 3'd3,
    T5_ACT   = 3'd4,
    T10_ACT  = 3'd5,
    T15_ACT  = 3'd6,
    COMPLETE = 3'd7
  } state_t;

  state_t        state;
  logic [3:0]    count;
  logic [PW-1:0] presc;
  logic          timeout;
  logic          tick;

  function automatic state_t next_preset(input state_t s);
    case (s)
      INACTIVE: next_preset = T5;
      T5:       next_preset = T10;
      T10:      next_preset = T15;
      default:  next_preset = INACTIVE;
    endcase
  endfunction

  function automatic state_t armed(input state_t s);
    case (s)
      T5:      armed = T5_ACT;
      T10:     armed = T10_ACT;
      default: armed = T15_ACT;
    endcase
  endfunction

  function automatic logic [3:0] preset_secs(input state_t s);
    case (s)
      T5_ACT:  preset_secs = 4'd5;
      T10_ACT: preset_secs = 4'd10;
      default: preset_secs = 4'd15;
    endcase
  endfunction

  assign tick = (presc == TICK_LAST);

  // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= INACTIVE;
      count   <= '0;
      presc   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        INACTIVE, T5, T10, T15: begin
          presc <= '0;
          if (i_btnTimer) begin
            state <= next_preset(state);
          end else if (i_btnStart && i_fanOn && state != INACTIVE) begin
            state <= armed(state);
            count <= '0;
          end
        end
        T5_ACT, T10_ACT, T15_ACT: begin
          // Cancel outranks a coincident tick, even the one that would complete the run.
          if (i_btnTimer || !i_fanOn) begin
            state <= INACTIVE;
            count <= '0;
            presc <= '0;
          end else if (tick) begin
            presc <= '0;
            if (count == preset_secs(state) - 4'd1) begin
              state   <= COMPLETE;
              count   <= preset_secs(state);
              timeout <= 1'b1;
            end else begin
              count <= count + 4'd1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        COMPLETE: begin
          if (i_btnTimer || i_btnStart) begin
            state <= INACTIVE;
            count <= '0;
            presc <= '0;
          end else begin
`ifdef TIMER_AUTO_CLEAR_EN
            if (tick) begin
              state <= INACTIVE;
              count <= '0;
              presc <= '0;
            end else begin
              presc <= presc + PW'(1);
            end
`else
            presc <= '0;
`endif
          end
        end
        default: begin
          state <= INACTIVE;
          count <= '0;
          presc <= '0;
        end
      endcase
    end
  end

  assign o_timerState = state;
  assign o_downCount  = {28'd0, count};
  assign o_timeout    = timeout;

endmodule
